// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
package prog_loader_pkg;

  localparam int unsigned IW_DEF       = 9;
  localparam int unsigned AW_DEF       = 6;
  localparam int unsigned RST_HOLD_DEF = 4;
  localparam int unsigned DEPTH_DEF    = 1 << AW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    HOLD,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready word stream from the host link into the program loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned IW = IW_DEF
);
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader_csum.sv
// XOR accumulator over written words; compares against the trailing checksum beat.
module loader_csum
  import prog_loader_pkg::*;
#(
  parameter int unsigned IW = IW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          acc_en,
  input  logic [IW-1:0] acc_data,
  input  logic [IW-1:0] cmp_data,
  output logic          match_c
);

  logic [IW-1:0] acc;

  always_ff @(posedge Clk) begin
    if (Reset || clear) acc <= '0;
    else if (acc_en)    acc <= acc ^ acc_data;
  end

  assign match_c = (acc == cmp_data);

endmodule

// File: rtl/prog_loader.sv
// Fills the instruction store from a word stream and holds the core in reset until done.
// Optional LOADER_CHECKSUM_EN: final beat is an XOR checksum of the program, not written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IW       = IW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load_start,
  prog_loader_if.slave  s,
  output logic          imem_wr_en,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wr_data,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned HW    = $clog2(RST_HOLD) + 1;

  state_t        state, next_state;
  logic [HW-1:0] hold_cnt;
  logic          start_c, accept_c, full_c, csum_beat_c, csum_ok_c, overflow_c, write_c;

  assign start_c  = load_start && (state == IDLE || state == RUN || state == ERROR);
  assign accept_c = s.in_valid && s.in_ready;
  assign full_c   = (word_count == CW'(DEPTH));

`ifdef LOADER_CHECKSUM_EN
  assign csum_beat_c = s.in_last;

  loader_csum #(.IW(IW)) u_csum (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (start_c),
    .acc_en   (write_c),
    .acc_data (s.in_data),
    .cmp_data (s.in_data),
    .match_c  (csum_ok_c)
  );
`else
  assign csum_beat_c = 1'b0;
  assign csum_ok_c   = 1'b1;
`endif

  assign overflow_c = accept_c && full_c && !csum_beat_c;
  assign write_c    = accept_c && !full_c && !csum_beat_c;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RUN, ERROR: if (start_c) next_state = LOAD;
      LOAD: begin
        if (overflow_c)                    next_state = ERROR;
        else if (accept_c && s.in_last)    next_state = csum_ok_c ? FLUSH : ERROR;
      end
      FLUSH:                               next_state = HOLD;
      HOLD: if (hold_cnt == HW'(RST_HOLD - 1)) next_state = RUN;
      default:                             next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s.in_ready <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      s.in_ready <= (next_state == LOAD);
      core_reset <= (next_state != RUN);
      load_done  <= (next_state == RUN);
      load_err   <= (next_state == ERROR);
    end
  end

  // Write port is one cycle behind the accepted beat.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      word_count   <= '0;
      hold_cnt     <= '0;
    end else begin
      imem_wr_en <= write_c;
      hold_cnt   <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (start_c) begin
        word_count <= '0;
      end else if (write_c) begin
        imem_addr    <= word_count[AW-1:0];
        imem_wr_data <= s.in_data;
        word_count   <= word_count + 1'b1;
      end
    end
  end

endmodule
